// File: rtl/tlul_reg_slave.sv
// TL-UL register slave: single outstanding request, one-cycle response latency.
// Register 0 is mirrored on o_reg0 for board-level LEDs.
module tlul_reg_slave #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8,
   parameter int SRC_W  = 4,
   parameter int NREGS  = 16
) (
   input  logic                i_clk,
   input  logic                i_reset_n,
   input  logic                i_a_valid,
   output logic                o_a_ready,
   input  logic [2:0]          i_a_opcode,
   input  logic [2:0]          i_a_param,
   input  logic [1:0]          i_a_size,
   input  logic [SRC_W-1:0]    i_a_source,
   input  logic [ADDR_W-1:0]   i_a_address,
   input  logic [DATA_W/8-1:0] i_a_mask,
   input  logic [DATA_W-1:0]   i_a_data,
   output logic                o_d_valid,
   input  logic                i_d_ready,
   output logic [2:0]          o_d_opcode,
   output logic [1:0]          o_d_size,
   output logic [SRC_W-1:0]    o_d_source,
   output logic [DATA_W-1:0]   o_d_data,
   output logic                o_d_denied,
   output logic [DATA_W-1:0]   o_reg0
);

   localparam int NBYTES = DATA_W / 8;
   localparam int LANE_W = $clog2(NBYTES);
   localparam int IDX_W  = $clog2(NREGS);
   localparam int SPAN   = NREGS * NBYTES;

   typedef enum logic {
      IDLE,
      RESP
   } state_t;

   typedef struct packed {
      logic [2:0]        opcode;
      logic [1:0]        size;
      logic [SRC_W-1:0]  source;
      logic [DATA_W-1:0] data;
      logic              denied;
   } d_beat_t;

   state_t            state_q;
   state_t            state_d;
   logic              a_ready_q;
   logic              d_valid_q;
   d_beat_t           beat_q;
   d_beat_t           beat_d;
   logic [DATA_W-1:0] regs [NREGS];

   logic              accept;
   logic              is_get;
   logic              is_put;
   logic              bad_op;
   logic              too_big;
   logic              misaligned;
   logic              out_range;
   logic              mask_out;
   logic              full_bad;
   logic              err;
   logic [NBYTES-1:0] span;
   logic [IDX_W-1:0]  idx;
   logic [LANE_W-1:0] lane_off;
   logic [ADDR_W-1:0] align;
   int                lo;
   int                hi;
   logic              param_unused;

   assign param_unused = ^i_a_param;

   assign accept   = i_a_valid & a_ready_q;
   assign idx      = i_a_address[LANE_W +: IDX_W];
   assign lane_off = i_a_address[LANE_W-1:0];

   always_comb begin
      is_get = 1'b0;
      is_put = 1'b0;
      bad_op = 1'b0;
      unique case (i_a_opcode)
         3'd0, 3'd1: is_put = 1'b1;
         3'd4:       is_get = 1'b1;
         default:    bad_op = 1'b1;
      endcase
   end

   // Byte lanes covered by the addressed 2**size span within the word
   always_comb begin
      span = '0;
      lo   = 32'(lane_off);
      hi   = lo + (1 << i_a_size);
      for (int i = 0; i < NBYTES; i++) begin
         if (i >= lo && i < hi) begin
            span[i] = 1'b1;
         end
      end
   end

   assign align      = (ADDR_W'(1) << i_a_size) - ADDR_W'(1);
   assign too_big    = {30'd0, i_a_size} > 32'(LANE_W);
   assign misaligned = |(i_a_address & align);
   assign out_range  = {1'b0, i_a_address} >= (ADDR_W+1)'(SPAN);
   assign mask_out   = |(i_a_mask & ~span);
   assign full_bad   = (i_a_opcode == 3'd0) && (i_a_mask != span);

   assign err = bad_op | too_big | misaligned |
                out_range | mask_out | full_bad;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (accept) state_d = RESP;
         RESP: if (i_d_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      beat_d = beat_q;
      if (accept) begin
         beat_d.opcode = is_get ? 3'd1 : 3'd0;
         beat_d.size   = i_a_size;
         beat_d.source = i_a_source;
         beat_d.denied = err;
         beat_d.data   = (is_get && !err) ? regs[idx] : '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q   <= IDLE;
         a_ready_q <= 1'b0;
         d_valid_q <= 1'b0;
         beat_q    <= '0;
      end else begin
         state_q   <= state_d;
         a_ready_q <= (state_d == IDLE);
         d_valid_q <= (state_d == RESP);
         beat_q    <= beat_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         for (int r = 0; r < NREGS; r++) begin
            regs[r] <= '0;
         end
      end else if (accept && is_put && !err) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (i_a_mask[b]) begin
               regs[idx][8*b +: 8] <= i_a_data[8*b +: 8];
            end
         end
      end
   end

   assign o_a_ready  = a_ready_q;
   assign o_d_valid  = d_valid_q;
   assign o_d_opcode = beat_q.opcode;
   assign o_d_size   = beat_q.size;
   assign o_d_source = beat_q.source;
   assign o_d_data   = beat_q.data;
   assign o_d_denied = beat_q.denied;
   assign o_reg0     = regs[0];

endmodule

// File: tb/tb_tlul_reg_slave.sv
// Scoreboard bench for tlul_reg_slave: stimulus queues expected D beats,
// a negedge monitor pops and compares each completed beat.
module tb_tlul_reg_slave;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        a_valid = 1'b0;
   logic        a_ready;
   logic [2:0]  a_opcode = '0;
   logic [2:0]  a_param = '0;
   logic [1:0]  a_size = '0;
   logic [3:0]  a_source = '0;
   logic [7:0]  a_address = '0;
   logic [3:0]  a_mask = '0;
   logic [31:0] a_data = '0;
   logic        d_valid;
   logic        d_ready = 1'b1;
   logic [2:0]  d_opcode;
   logic [1:0]  d_size;
   logic [3:0]  d_source;
   logic [31:0] d_data;
   logic        d_denied;
   logic [31:0] reg0;

   typedef struct packed {
      logic [2:0]  op;
      logic [1:0]  size;
      logic [3:0]  src;
      logic [31:0] data;
      logic        den;
   } beat_t;

   beat_t expq[$];
   beat_t mon_act;
   beat_t mon_exp;
   int    vectors = 0;
   int    miscompares = 0;

   tlul_reg_slave dut (
      .i_clk       (clk),
      .i_reset_n   (rst_n),
      .i_a_valid   (a_valid),
      .o_a_ready   (a_ready),
      .i_a_opcode  (a_opcode),
      .i_a_param   (a_param),
      .i_a_size    (a_size),
      .i_a_source  (a_source),
      .i_a_address (a_address),
      .i_a_mask    (a_mask),
      .i_a_data    (a_data),
      .o_d_valid   (d_valid),
      .i_d_ready   (d_ready),
      .o_d_opcode  (d_opcode),
      .o_d_size    (d_size),
      .o_d_source  (d_source),
      .o_d_data    (d_data),
      .o_d_denied  (d_denied),
      .o_reg0      (reg0)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && d_valid && d_ready) begin
         mon_act.op   = d_opcode;
         mon_act.size = d_size;
         mon_act.src  = d_source;
         mon_act.data = d_data;
         mon_act.den  = d_denied;
         vectors++;
         if (expq.size() == 0) begin
            miscompares++;
            $display("FAIL d_beat: unexpected op=%0d src=%0d data=%h den=%0b",
                     d_opcode, d_source, d_data, d_denied);
         end else begin
            mon_exp = expq.pop_front();
            if (mon_act !== mon_exp) begin
               miscompares++;
               $display("FAIL d_beat: got op=%0d size=%0d src=%0d data=%h den=%0b expected op=%0d size=%0d src=%0d data=%h den=%0b",
                        mon_act.op, mon_act.size, mon_act.src, mon_act.data,
                        mon_act.den, mon_exp.op, mon_exp.size, mon_exp.src,
                        mon_exp.data, mon_exp.den);
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accept edge
   task automatic send(input logic [2:0] op, input logic [1:0] size,
                       input logic [7:0] addr, input logic [3:0] mask,
                       input logic [31:0] data, input logic [3:0] src,
                       input logic [2:0] eop, input logic [31:0] edata,
                       input logic eden, input bit push);
      int    n = 0;
      beat_t e;
      a_valid   = 1'b1;
      a_opcode  = op;
      a_size    = size;
      a_address = addr;
      a_mask    = mask;
      a_data    = data;
      a_source  = src;
      while (!a_ready && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!a_ready) begin
         vectors++;
         miscompares++;
         $display("FAIL a_ready_timeout: got 0 expected 1");
         a_valid = 1'b0;
         return;
      end
      e.op   = eop;
      e.size = size;
      e.src  = src;
      e.data = edata;
      e.den  = eden;
      if (push) expq.push_back(e);
      @(posedge clk);
      #1;
      a_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!a_ready && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!a_ready) begin
         vectors++;
         miscompares++;
         $display("FAIL idle_timeout: got a_ready=0 expected 1");
      end
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_a_ready", 32'(a_ready), 32'd0);
      check("rst_d_valid", 32'(d_valid), 32'd0);
      check("rst_reg0", reg0, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rel_a_ready", 32'(a_ready), 32'd1);

      send(3'd0, 2'd2, 8'h00, 4'hF, 32'hA5A5_0F0F, 4'd3, 3'd0, 32'd0, 1'b0, 1);
      check("put_d_valid", 32'(d_valid), 32'd1);
      check("put_reg0", reg0, 32'hA5A5_0F0F);

      send(3'd1, 2'd0, 8'h04, 4'h1, 32'h0000_00EE, 4'd1, 3'd0, 32'd0, 1'b0, 1);
      send(3'd4, 2'd2, 8'h04, 4'hF, 32'd0, 4'd2, 3'd1, 32'h0000_00EE, 1'b0, 1);
      send(3'd1, 2'd0, 8'h05, 4'h2, 32'hFFFF_ABFF, 4'd1, 3'd0, 32'd0, 1'b0, 1);
      send(3'd4, 2'd2, 8'h04, 4'hF, 32'd0, 4'd2, 3'd1, 32'h0000_ABEE, 1'b0, 1);

      send(3'd0, 2'd2, 8'h08, 4'hF, 32'h1234_5678, 4'd4, 3'd0, 32'd0, 1'b0, 1);
      wait_idle();
      d_ready = 1'b0;
      send(3'd4, 2'd2, 8'h08, 4'hF, 32'd0, 4'd5, 3'd1, 32'h1234_5678, 1'b0, 1);
      for (int i = 0; i < 5; i++) begin
         check("stall_d_valid", 32'(d_valid), 32'd1);
         check("stall_d_data", d_data, 32'h1234_5678);
         check("stall_a_ready", 32'(a_ready), 32'd0);
         @(posedge clk);
         #1;
      end
      d_ready = 1'b1;
      @(posedge clk);
      #1;
      check("unstall_a_ready", 32'(a_ready), 32'd1);

      send(3'd4, 2'd2, 8'h40, 4'hF, 32'd0, 4'd6, 3'd1, 32'd0, 1'b1, 1);
      send(3'd0, 2'd2, 8'h02, 4'hF, 32'hFFFF_FFFF, 4'd7, 3'd0, 32'd0, 1'b1, 1);
      send(3'd2, 2'd2, 8'h00, 4'hF, 32'hDEAD_BEEF, 4'd8, 3'd0, 32'd0, 1'b1, 1);
      send(3'd0, 2'd2, 8'h00, 4'h3, 32'hFFFF_FFFF, 4'd9, 3'd0, 32'd0, 1'b1, 1);
      send(3'd1, 2'd1, 8'h06, 4'h1, 32'hFFFF_FFFF, 4'd10, 3'd0, 32'd0, 1'b1, 1);
      send(3'd4, 2'd3, 8'h00, 4'hF, 32'd0, 4'd11, 3'd1, 32'd0, 1'b1, 1);
      send(3'd4, 2'd2, 8'h3C, 4'hF, 32'd0, 4'd12, 3'd1, 32'd0, 1'b0, 1);
      send(3'd1, 2'd1, 8'h0A, 4'hC, 32'hBEEF_0000, 4'd1, 3'd0, 32'd0, 1'b0, 1);
      send(3'd4, 2'd2, 8'h08, 4'hF, 32'd0, 4'd2, 3'd1, 32'hBEEF_5678, 1'b0, 1);
      wait_idle();
      check("err_reg0", reg0, 32'hA5A5_0F0F);
      send(3'd4, 2'd2, 8'h00, 4'hF, 32'd0, 4'd3, 3'd1, 32'hA5A5_0F0F, 1'b0, 1);
      send(3'd4, 2'd2, 8'h04, 4'hF, 32'd0, 4'd4, 3'd1, 32'h0000_ABEE, 1'b0, 1);

      wait_idle();
      d_ready = 1'b0;
      send(3'd0, 2'd2, 8'h0C, 4'hF, 32'h1111_1111, 4'd13, 3'd0, 32'd0, 1'b0, 0);
      check("pre_rst_d_valid", 32'(d_valid), 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("mid_rst_d_valid", 32'(d_valid), 32'd0);
      check("mid_rst_a_ready", 32'(a_ready), 32'd0);
      @(posedge clk);
      #1;
      d_ready = 1'b1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_reg0", reg0, 32'd0);
      send(3'd4, 2'd2, 8'h00, 4'hF, 32'd0, 4'd14, 3'd1, 32'd0, 1'b0, 1);
      send(3'd4, 2'd2, 8'h04, 4'hF, 32'd0, 4'd15, 3'd1, 32'd0, 1'b0, 1);
      send(3'd4, 2'd2, 8'h08, 4'hF, 32'd0, 4'd0, 3'd1, 32'd0, 1'b0, 1);
      send(3'd4, 2'd2, 8'h0C, 4'hF, 32'd0, 4'd1, 3'd1, 32'd0, 1'b0, 1);

      n = 0;
      while (expq.size() != 0 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      repeat (5) @(posedge clk);
      #1;
      check("queue_drained", 32'(expq.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
